deck_dealer: RTL and testbench

- Sequential card deck that consumes the next-address shuffle function.
- Drives the current index `Addr_i`, samples the returned `Addr_j`, and performs an in-place 52-entry swap shuffle.
- Afterwards, deals cards one at a time to the game FSM over a request/valid handshake.
- Sits between the shuffle-address generator and the blackjack game controller.

---
 rtl/deck_dealer.sv | 161 ++++++++++++++++
 tb/tb_deck_dealer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/deck_dealer.sv
// Card deck: fills 0..51, in-place swap shuffle driven by an external address
// generator (Addr_i out, Addr_j in), then deals one card per request.
module deck_dealer #(
  parameter int DECK_SIZE = 52,
  parameter int IDX_W     = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Shuffle_req,
  input  logic             Deal_req,
  input  logic [IDX_W-1:0] Addr_j,
  output logic [IDX_W-1:0] Addr_i,
  output logic [IDX_W-1:0] Card,
  output logic [3:0]       Card_rank,
  output logic [1:0]       Card_suit,
  output logic             Card_valid,
  output logic             Busy,
  output logic             Deck_empty,
  output logic [IDX_W-1:0] Cards_left
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LATCH,
    SWAP,
    READY
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DECK_SIZE - 1);
  localparam logic [IDX_W-1:0] SIZE = IDX_W'(DECK_SIZE);

  state_t           r_state;
  logic [IDX_W-1:0] r_deck [0:DECK_SIZE-1];
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] r_jq;
  logic [IDX_W-1:0] r_addr_i;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_card;
  logic [3:0]       r_rank;
  logic [1:0]       r_suit;
  logic             r_valid;
  logic             r_busy;
  logic             r_empty;
  logic [IDX_W-1:0] r_left;

  logic [IDX_W-1:0] w_top;
  logic [1:0]       w_suit;
  logic [IDX_W-1:0] w_base;
  logic [3:0]       w_rank;

  // Rank/suit of the card at the deal pointer, ready for the registered deal.
  always_comb begin
    w_top  = r_deck[r_ptr];
    w_suit = 2'd0;
    w_base = '0;
    if (w_top >= IDX_W'(39)) begin
      w_suit = 2'd3;
      w_base = IDX_W'(39);
    end else if (w_top >= IDX_W'(26)) begin
      w_suit = 2'd2;
      w_base = IDX_W'(26);
    end else if (w_top >= IDX_W'(13)) begin
      w_suit = 2'd1;
      w_base = IDX_W'(13);
    end
    w_rank = 4'(w_top - w_base + IDX_W'(1));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= IDLE;
      r_k      <= '0;
      r_jq     <= '0;
      r_addr_i <= '0;
      r_ptr    <= '0;
      r_card   <= '0;
      r_rank   <= '0;
      r_suit   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_empty  <= 1'b1;
      r_left   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Shuffle_req) begin
            r_state <= INIT;
            r_k     <= '0;
            r_busy  <= 1'b1;
          end
        end
        INIT: begin
          if (r_k == LAST) begin
            r_state  <= LATCH;
            r_addr_i <= '0;
          end else begin
            r_k <= r_k + IDX_W'(1);
          end
        end
        LATCH: begin
          // Out-of-range partners degrade to a self-swap.
          r_jq    <= (Addr_j >= SIZE) ? r_addr_i : Addr_j;
          r_state <= SWAP;
        end
        SWAP: begin
          if (r_addr_i == LAST) begin
            r_state  <= READY;
            r_addr_i <= '0;
            r_ptr    <= '0;
            r_left   <= SIZE;
            r_empty  <= 1'b0;
            r_busy   <= 1'b0;
          end else begin
            r_addr_i <= r_addr_i + IDX_W'(1);
            r_state  <= LATCH;
          end
        end
        READY: begin
          if (Shuffle_req) begin
            r_state <= INIT;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_left  <= '0;
            r_empty <= 1'b1;
          end else if (Deal_req && !r_empty) begin
            r_card  <= w_top;
            r_rank  <= w_rank;
            r_suit  <= w_suit;
            r_valid <= 1'b1;
            r_ptr   <= r_ptr + IDX_W'(1);
            r_left  <= r_left - IDX_W'(1);
            r_empty <= (r_left == IDX_W'(1));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Deck storage carries no reset; INIT rebuilds it before every shuffle.
  always_ff @(posedge Clk) begin
    if (r_state == INIT) begin
      r_deck[r_k] <= r_k;
    end else if (r_state == SWAP) begin
      r_deck[r_addr_i] <= r_deck[r_jq];
      r_deck[r_jq]     <= r_deck[r_addr_i];
    end
  end

  assign Addr_i     = r_addr_i;
  assign Card       = r_card;
  assign Card_rank  = r_rank;
  assign Card_suit  = r_suit;
  assign Card_valid = r_valid;
  assign Busy       = r_busy;
  assign Deck_empty = r_empty;
  assign Cards_left = r_left;

endmodule

// File: tb/tb_deck_dealer.sv
// Self-checking bench for deck_dealer: an address-generator stand-in and a
// shuffle/deal reference model built from plain arrays and a queue.
module tb_deck_dealer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Shuffle_req = 1'b0;
  logic       Deal_req = 1'b0;
  logic [5:0] Addr_j;
  logic [5:0] Addr_i;
  logic [5:0] Card;
  logic [3:0] Card_rank;
  logic [1:0] Card_suit;
  logic       Card_valid;
  logic       Busy;
  logic       Deck_empty;
  logic [5:0] Cards_left;

  int total = 0;
  int bad = 0;
  int mode = 0;
  logic [5:0] rnd_tab [0:51];
  int exp_q[$];

  deck_dealer #(.DECK_SIZE(52), .IDX_W(6)) dut (
    .Clk(Clk), .Rst(Rst), .Shuffle_req(Shuffle_req), .Deal_req(Deal_req),
    .Addr_j(Addr_j), .Addr_i(Addr_i), .Card(Card), .Card_rank(Card_rank),
    .Card_suit(Card_suit), .Card_valid(Card_valid), .Busy(Busy),
    .Deck_empty(Deck_empty), .Cards_left(Cards_left)
  );

  always #5 Clk = ~Clk;

  function automatic int jfun(input int i);
    case (mode)
      0: return i;
      1: return 0;
      2: return 60;
      default: return int'(rnd_tab[i]);
    endcase
  endfunction

  always_comb Addr_j = 6'(jfun(int'(Addr_i)));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic new_table();
    for (int i = 0; i < 52; i++) rnd_tab[i] = 6'($urandom_range(63));
  endtask

  // Fisher-Yates-style reference: identity deck, swap i with its partner.
  task automatic model_shuffle();
    int d[52];
    int j, t;
    for (int i = 0; i < 52; i++) d[i] = i;
    for (int i = 0; i < 52; i++) begin
      j = jfun(i);
      if (j >= 52) j = i;
      t = d[i]; d[i] = d[j]; d[j] = t;
    end
    exp_q = {};
    for (int i = 0; i < 52; i++) exp_q.push_back(d[i]);
  endtask

  // Shuffle_req (optionally with Deal_req) sampled on one edge, then wait for Busy to drop.
  task automatic run_shuffle(input bit inject, input bit with_deal);
    int n;
    int vseen;
    Shuffle_req = 1'b1;
    Deal_req = with_deal;
    tick();
    Shuffle_req = 1'b0;
    Deal_req = 1'b0;
    n = 1;
    vseen = 0;
    chk("busy_rise", Busy, 1);
    chk("start_no_valid", Card_valid, 0);
    chk("start_left", Cards_left, 0);
    chk("start_empty", Deck_empty, 1);
    while (Busy === 1'b1 && n < 400) begin
      if (inject && n == 40) Deal_req = 1'b1;
      if (inject && n == 90) Shuffle_req = 1'b1;
      tick();
      n++;
      Deal_req = 1'b0;
      Shuffle_req = 1'b0;
      if (Card_valid === 1'b1) vseen++;
    end
    chk("shuffle_latency", n, 157);
    chk("busy_valid", vseen, 0);
    chk("ready_left", Cards_left, 52);
    chk("ready_empty", Deck_empty, 0);
    chk("ready_addr_i", Addr_i, 0);
    model_shuffle();
  endtask

  task automatic deal_one();
    int e;
    Deal_req = 1'b1;
    tick();
    Deal_req = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("deal_valid", Card_valid, 1);
      chk("deal_card", Card, e);
      chk("deal_rank", Card_rank, e % 13 + 1);
      chk("deal_suit", Card_suit, e / 13);
      chk("deal_left", Cards_left, exp_q.size());
      chk("deal_empty", Deck_empty, exp_q.size() == 0);
      tick();
      chk("pulse_width", Card_valid, 0);
      chk("card_hold", Card, e);
    end else begin
      chk("empty_no_valid", Card_valid, 0);
      chk("empty_left", Cards_left, 0);
      chk("empty_flag", Deck_empty, 1);
    end
  endtask

  initial begin
    int pulses;
    int e;
    int last_card;

    // Reset values
    Rst = 1'b1;
    tick(); tick();
    Rst = 1'b0;
    chk("rst_addr_i", Addr_i, 0);
    chk("rst_card", Card, 0);
    chk("rst_rank", Card_rank, 0);
    chk("rst_suit", Card_suit, 0);
    chk("rst_valid", Card_valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_empty", Deck_empty, 1);
    chk("rst_left", Cards_left, 0);
    Deal_req = 1'b1;
    tick();
    Deal_req = 1'b0;
    chk("idle_deal_ignored", Card_valid, 0);

    // Self-swap partner: identity order, card 13 is Ace of suit 1
    mode = 0;
    run_shuffle(1'b0, 1'b0);
    for (int i = 0; i < 52; i++) deal_one();
    deal_one();
    chk("hold_after_empty", Card, 51);

    // Partner always 0: order 51,0,1..50; deal held high for 60 cycles
    mode = 1;
    run_shuffle(1'b1, 1'b0);
    chk("first_is_51", exp_q[0], 51);
    pulses = 0;
    last_card = 0;
    Deal_req = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      chk("held_valid", Card_valid, c < 52);
      if (Card_valid === 1'b1 && exp_q.size() > 0) begin
        pulses++;
        e = exp_q.pop_front();
        last_card = e;
        chk("held_card", Card, e);
        chk("held_left", Cards_left, 51 - c);
      end
    end
    Deal_req = 1'b0;
    chk("held_pulses", pulses, 52);
    chk("held_final_left", Cards_left, 0);
    chk("held_hold_card", Card, last_card);

    // Out-of-range partner: no swaps
    mode = 2;
    run_shuffle(1'b0, 1'b0);
    for (int i = 0; i < 52; i++) chk("noswap_order", exp_q[i], i);
    for (int i = 0; i < 52; i++) deal_one();

    // Random partners; shuffle+deal collision after 10 deals
    mode = 3;
    new_table();
    run_shuffle(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) deal_one();
    new_table();
    run_shuffle(1'b1, 1'b1);
    for (int i = 0; i < 52; i++) deal_one();

    // Reset at shuffle cycle 80 with ignored pulses during Busy
    new_table();
    Shuffle_req = 1'b1;
    tick();
    Shuffle_req = 1'b0;
    for (int n = 1; n < 80; n++) begin
      if (n == 30) Deal_req = 1'b1;
      if (n == 50) Shuffle_req = 1'b1;
      tick();
      Deal_req = 1'b0;
      Shuffle_req = 1'b0;
      chk("mid_busy", Busy, 1);
      chk("mid_no_valid", Card_valid, 0);
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("midrst_busy", Busy, 0);
    chk("midrst_empty", Deck_empty, 1);
    chk("midrst_addr_i", Addr_i, 0);
    chk("midrst_left", Cards_left, 0);
    chk("midrst_valid", Card_valid, 0);
    Deal_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("midrst_deal_ignored", Card_valid, 0);
      chk("midrst_stays_idle", Busy, 0);
    end
    Deal_req = 1'b0;
    run_shuffle(1'b0, 1'b0);
    for (int i = 0; i < 52; i++) deal_one();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
